// File: rtl/ctr_encryption.sv
// AES-256 counter-mode encryptor for a fixed 8 x 128-bit message. One AES round per cycle.
// Free-running: capture inputs, encrypt all blocks, publish the result atomically, repeat.
module ctr_encryption (
   input  logic          clk,
   input  logic          rst,
   input  logic [1023:0] plaintext_in,
   input  logic [255:0]  key,
   input  logic [127:0]  iv,
   output logic [1999:0] text
);

   typedef enum logic [2:0] {StCapture, StLoad, StRound, StStore, StDone} state_e;

   state_e          state_q, state_d;
   logic [1023:0]   pt_q, pt_d;
   logic [255:0]    key_q, key_d;
   logic [127:0]    ctr_q, ctr_d;
   logic [2:0]      blk_q, blk_d;
   logic [3:0]      rnd_q, rnd_d;
   logic [127:0]    aes_q, aes_d;
   logic [127:0]    rk_lo_q, rk_lo_d;
   logic [127:0]    rk_hi_q, rk_hi_d;
   logic [1023:0]   res_q, res_d;
   logic [1023:0]   text_q, text_d;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      // b^254 as the product of b^(2^i), i = 1..7; this also maps 0 to 0
      sq  = b;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [2:0] idx);
      logic [7:0] r;
      case (idx)
         3'd1:    r = 8'h01;
         3'd2:    r = 8'h02;
         3'd3:    r = 8'h04;
         3'd4:    r = 8'h08;
         3'd5:    r = 8'h10;
         3'd6:    r = 8'h20;
         3'd7:    r = 8'h40;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Round key r from round keys r-2 (k2) and r-1 (k1); word j sits at bits [32j+31:32j].
   function automatic logic [127:0] next_rk(input logic [127:0] k2, input logic [127:0] k1,
                                            input logic [3:0] r);
      logic [31:0]  t;
      logic [127:0] o;
      t = k1[127:96];
      if (!r[0]) t = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rcon(r[3:1])};
      else       t = sub_word(t);
      o[31:0]   = k2[31:0]   ^ t;
      o[63:32]  = k2[63:32]  ^ o[31:0];
      o[95:64]  = k2[95:64]  ^ o[63:32];
      o[127:96] = k2[127:96] ^ o[95:64];
      return o;
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   sb [16];
      logic [7:0]   sr [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int j = 0; j < 16; j++) sb[j] = sbox(s[8*j +: 8]);
      // Row r of column c takes row r of column c+r
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         if (last) begin
            o[32*c +: 32] = {a3, a2, a1, a0};
         end else begin
            o[32*c +: 32] = {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
         end
      end
      return o ^ rk;
   endfunction

   always_comb begin
      state_d = state_q;
      pt_d    = pt_q;
      key_d   = key_q;
      ctr_d   = ctr_q;
      blk_d   = blk_q;
      rnd_d   = rnd_q;
      aes_d   = aes_q;
      rk_lo_d = rk_lo_q;
      rk_hi_d = rk_hi_q;
      res_d   = res_q;
      text_d  = text_q;
      case (state_q)
         StCapture: begin
            pt_d    = plaintext_in;
            key_d   = key;
            ctr_d   = iv;
            blk_d   = 3'd0;
            state_d = StLoad;
         end
         StLoad: begin
            aes_d   = ctr_q ^ key_q[127:0];
            rk_lo_d = key_q[127:0];
            rk_hi_d = key_q[255:128];
            rnd_d   = 4'd1;
            state_d = StRound;
         end
         StRound: begin
            aes_d   = aes_round(aes_q, rk_hi_q, rnd_q == 4'd14);
            rk_lo_d = rk_hi_q;
            rk_hi_d = next_rk(rk_lo_q, rk_hi_q, rnd_q + 4'd1);
            rnd_d   = rnd_q + 4'd1;
            if (rnd_q == 4'd14) state_d = StStore;
         end
         StStore: begin
            res_d[{blk_q, 7'd0} +: 128] = aes_q ^ pt_q[{blk_q, 7'd0} +: 128];
            ctr_d   = ctr_q + 128'd1;
            blk_d   = blk_q + 3'd1;
            state_d = (blk_q == 3'd7) ? StDone : StLoad;
         end
         StDone: begin
            text_d  = res_q;
            state_d = StCapture;
         end
         default: state_d = StCapture;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StCapture;
         pt_q    <= '0;
         key_q   <= '0;
         ctr_q   <= '0;
         blk_q   <= '0;
         rnd_q   <= '0;
         aes_q   <= '0;
         rk_lo_q <= '0;
         rk_hi_q <= '0;
         res_q   <= '0;
         text_q  <= '0;
      end else begin
         state_q <= state_d;
         pt_q    <= pt_d;
         key_q   <= key_d;
         ctr_q   <= ctr_d;
         blk_q   <= blk_d;
         rnd_q   <= rnd_d;
         aes_q   <= aes_d;
         rk_lo_q <= rk_lo_d;
         rk_hi_q <= rk_hi_d;
         res_q   <= res_d;
         text_q  <= text_d;
      end
   end

   assign text = {976'b0, text_q};

endmodule

// File: tb/tb_ctr_encryption.sv
// Bench for ctr_encryption: table-driven AES-256 reference model and a scoreboard of pass results.
module tb_ctr_encryption;

   logic          clk = 1'b0;
   logic          rst;
   logic [1023:0] plaintext_in;
   logic [255:0]  key;
   logic [127:0]  iv;
   logic [1999:0] text;

   always #5 clk = ~clk;

   ctr_encryption dut (
      .clk          (clk),
      .rst          (rst),
      .plaintext_in (plaintext_in),
      .key          (key),
      .iv           (iv),
      .text         (text)
   );

   localparam logic [255:0]  KatKey = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0]  KatIv  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [1023:0] Pt3    = {16{64'h0123456789abcdef}};

   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;
   logic [7:0]    sbox_t [256];
   logic [1023:0] sb_q [$];
   logic [1999:0] prev_text;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // S-box table from the generator-3 walk over GF(2^8)
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      for (int n = 0; n < 255; n++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] aes256(input logic [255:0] k, input logic [127:0] blk);
      logic [7:0]   w [60][4];
      logic [7:0]   st [16];
      logic [7:0]   tmp [16];
      logic [7:0]   t [4];
      logic [7:0]   t0, rc, a0, a1, a2, a3;
      logic [127:0] out;
      rc = 8'h01;
      for (int i = 0; i < 8; i++)
         for (int b = 0; b < 4; b++) w[i][b] = k[8*(4*i+b) +: 8];
      for (int i = 8; i < 60; i++) begin
         for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
         if (i % 8 == 0) begin
            t0   = t[0];
            t[0] = sbox_t[t[1]] ^ rc;
            t[1] = sbox_t[t[2]];
            t[2] = sbox_t[t[3]];
            t[3] = sbox_t[t0];
            rc   = xt(rc);
         end else if (i % 8 == 4) begin
            for (int b = 0; b < 4; b++) t[b] = sbox_t[t[b]];
         end
         for (int b = 0; b < 4; b++) w[i][b] = w[i-8][b] ^ t[b];
      end
      for (int j = 0; j < 16; j++) st[j] = blk[8*j +: 8] ^ w[j/4][j%4];
      for (int r = 1; r <= 14; r++) begin
         for (int j = 0; j < 16; j++) tmp[j] = sbox_t[st[j]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) st[4*c+rr] = tmp[4*((c+rr)%4)+rr];
         if (r != 14) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int j = 0; j < 16; j++) st[j] = st[j] ^ w[4*r + j/4][j%4];
      end
      for (int j = 0; j < 16; j++) out[8*j +: 8] = st[j];
      return out;
   endfunction

   function automatic logic [1023:0] model_ct(input logic [1023:0] pt, input logic [255:0] k,
                                               input logic [127:0] v);
      logic [1023:0] ct;
      for (int i = 0; i < 8; i++) ct[128*i +: 128] = pt[128*i +: 128] ^ aes256(k, v + 128'(i));
      return ct;
   endfunction

   function automatic logic [1023:0] rand_wide();
      logic [1023:0] r;
      for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Entered at a negedge just before a CAPTURE edge; returns at the negedge after DONE.
   task automatic run_pass(input string tag, input logic [1023:0] pt, input logic [255:0] k,
                           input logic [127:0] v, input bit scramble);
      logic [1023:0] exp_ct;
      logic [1023:0] junk;
      bit            held;
      plaintext_in = pt;
      key          = k;
      iv           = v;
      sb_q.push_back(model_ct(pt, k, v));
      held = 1'b1;
      for (int c = 1; c <= 129; c++) begin
         @(posedge clk);
         #1;
         if (text !== prev_text) held = 1'b0;
         if (scramble && c == 30) begin
            junk         = rand_wide();
            plaintext_in = junk;
            key          = junk[1023:768];
            iv           = junk[127:0] ^ 128'h5a5a;
         end
      end
      check_eq({tag, "/hold"}, {127'b0, held}, 128'd1);
      @(posedge clk);
      #1;
      exp_ct = sb_q.pop_front();
      for (int i = 0; i < 8; i++)
         check_eq($sformatf("%s/blk%0d", tag, i), text[128*i +: 128], exp_ct[128*i +: 128]);
      check_eq({tag, "/hi_zero"}, {127'b0, |text[1999:1024]}, 128'd0);
      prev_text = {976'b0, exp_ct};
      @(negedge clk);
   endtask

   initial begin
      logic [1023:0] ct3;
      logic [1023:0] pa;
      logic [1023:0] pb;
      build_sbox();
      rst          = 1'b1;
      plaintext_in = '0;
      key          = '0;
      iv           = '0;
      prev_text    = '0;

      repeat (2) begin
         @(negedge clk);
         check_eq("rst_lo", text[127:0], 128'd0);
         check_eq("rst_hi", {127'b0, |text}, 128'd0);
      end
      rst = 1'b0;

      run_pass("kat1", '0, KatKey, KatIv, 1'b0);
      run_pass("kat2", '0, KatKey, KatIv, 1'b0);
      run_pass("kat3", '0, KatKey, KatIv, 1'b0);
      check_eq("kat_ks", text[127:0], 128'h8960494b9049fceabf456751cab7a28e);

      run_pass("pt3", Pt3, KatKey, KatIv, 1'b0);
      check_eq("kat_ct", text[127:0], 128'h88430c2c19e23105be662236431c6f61);

      ct3 = model_ct(Pt3, KatKey, KatIv);
      run_pass("rtrip", ct3, KatKey, KatIv, 1'b0);
      for (int i = 0; i < 8; i++)
         check_eq($sformatf("rtrip_pt%0d", i), text[128*i +: 128], Pt3[128*i +: 128]);

      pa = rand_wide();
      run_pass("scramble", pa, pa[1023:768] ^ KatKey, pa[127:0], 1'b1);

      run_pass("wrap", '0, KatKey, {{127{1'b1}}, 1'b0}, 1'b0);
      check_eq("wrap_blk2", text[383:256], aes256(KatKey, 128'd0));
      run_pass("iv0", '0, KatKey, 128'd0, 1'b0);

      // Abort a pass at cycle 60 with reset, then run a fresh pass on new inputs
      pa = rand_wide();
      pb = rand_wide();
      plaintext_in = pa;
      key          = pa[255:0];
      iv           = pa[1023:896];
      repeat (60) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("midrst_lo", text[127:0], 128'd0);
      check_eq("midrst_all", {127'b0, |text}, 128'd0);
      plaintext_in = pb;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      prev_text = '0;
      run_pass("after_rst", pb, pb[511:256], pb[127:0], 1'b1);
      run_pass("final", pa, pb[255:0], pa[127:0], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ctr_encryption.md
Name: ctr_encryption

Overview:
- AES-256 counter-mode (CTR) encryptor for a fixed 1024-bit message of 8 × 128-bit blocks, using one iterative AES-256 round datapath (one round per cycle).
- Free-running after reset: samples inputs, encrypts all 8 blocks, publishes the result atomically, then repeats.
- Sits between the message/key source and downstream consumers.
- CTR is symmetric, so the same block also decrypts.

Parameters:
None. The block count is fixed at 8 and the key length at 256 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset
- plaintext_in  input  1024  message; block i = plaintext_in[128i+127:128i], i=0..7
- key  input  256  AES-256 key
- iv  input  128  initial counter value
- text  output  2000  result register; ciphertext in [1023:0], bits [1999:1024] always 0

Interface (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: asynchronous, active-high. Clears text to 0 and all internal registers (captured inputs, counter, AES state, round keys, result buffer), and sets the FSM to CAPTURE. Asserting reset mid-pass aborts the pass; text stays 0 until a full pass completes after release.
- Byte order is little-endian on every bus: byte j = bits [8j+7:8j].
  - AES state column c = bytes 4c..4c+3.
  - Key word w[i] = key bytes 4i..4i+3, with byte 4i as the FIPS-197 first (most significant) byte of the word.
- Counter for block i = iv + i, plain 128-bit binary addition on the bus value, wrapping mod 2^128.
- Keystream block i = AES-256-Encrypt(key, counter_i), standard FIPS-197 with Nk=8 and Nr=14.
  - Round key r = w[4r..4r+3].
  - Round keys are generated on the fly from two 128-bit halves; no 15-entry table is required.
  - S-box may be a table or computed (GF(2^8) inverse plus affine); the result must be bit-exact either way.
- Ciphertext block i = plaintext block i XOR keystream block i.
- FSM:
  - CAPTURE (1 cycle): latch plaintext_in, key, iv; counter = iv; block index = 0. Go to LOAD.
  - LOAD (1 cycle): state = counter XOR round key 0; prepare round key 1. Go to ROUND.
  - ROUND (14 cycles, r=1..14): SubBytes, ShiftRows, MixColumns (skipped at r=14), AddRoundKey(r). After r=14, go to STORE.
  - STORE (1 cycle): buffer slice i = state XOR captured plaintext block i; counter += 1; index += 1. If index was 7, go to DONE, else go to LOAD.
  - DONE (1 cycle): text <= {976'b0, buffer}. Go to CAPTURE.
- Timing:
  - Pass length is 130 cycles (1 + 8×16 + 1). text updates exactly once per pass, on the edge leaving DONE.
  - Input changes during a pass are ignored until the next CAPTURE.
  - Output reflects new inputs at most 2 passes (260 cycles) after they change.
  - Between updates, text holds its value.
- Inputs that are X or undefined at CAPTURE yield an undefined pass result; the next pass with defined inputs must be correct.

Test Plan:
1. Reset: hold rst=1 for 2 cycles → text == 0 throughout. Release → text stays 0 until the first DONE, 130 cycles later.
2. Known-answer keystream: key=256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100, iv=128'hffeeddccbbaa99887766554433221100, plaintext_in=0, run 3 passes → text[127:0]==128'h8960494b9049fceabf456751cab7a28e (FIPS-197 C.3 byte-reversed); text[1999:1024]==0.
3. Same key/iv, plaintext_in=1024'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef → text[127:0]==128'h88430c2c19e23105be662236431c6f61.
4. Round-trip: feed text[1023:0] from test 3 back as plaintext_in with the same key/iv → text[1023:0] equals the original plaintext_in. Check every block, which also covers counter increments for i=1..7.
5. Counter wrap: iv=128'hffff…fffe, zero plaintext → block 2 keystream equals the keystream of iv=0 block 0 run separately; no X anywhere.
6. Reset mid-pass: assert rst at cycle 60 of a pass → text==0 immediately. Release → correct result appears after a full fresh pass; inputs changed mid-pass take effect only from the next CAPTURE.
